// File: rtl/line_mem_pkg.sv
// Shared types and default parameter values for the line memory.
package line_mem_pkg;

  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_MEM_BYTES  = 4096;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_ADDR_W     = 32;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/line_mem_arb.sv
// Two-way round-robin arbiter between the D-side and I-side requesters.
module line_mem_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic req_d,
  input  logic req_i,
  input  logic advance,
  output logic grant_d,
  output logic grant_i
);

  logic prio_d_q;

  assign grant_d = req_d && (!req_i || prio_d_q);
  assign grant_i = req_i && !grant_d;

  // The channel just served drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_d_q <= 1'b1;
    end else if (advance && (grant_d || grant_i)) begin
      prio_d_q <= grant_i;
    end
  end

endmodule

// File: rtl/line_mem.sv
// Dual-channel line-wide memory with fixed read latency and byte-enabled writes.
module line_mem
  import line_mem_pkg::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int MEM_BYTES  = DEF_MEM_BYTES,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req_i,
  input  logic [ADDR_W-1:0]       i_addr_i,
  output logic [8*LINE_BYTES-1:0] i_data_o,
  output logic                    i_ready_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_W-1:0]       d_addr_i,
  input  logic [LINE_BYTES-1:0]   d_be_i,
  input  logic [8*LINE_BYTES-1:0] d_wdata_i,
  output logic [8*LINE_BYTES-1:0] d_data_o,
  output logic                    d_ready_o,
  output logic                    busy_o
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINES  = MEM_BYTES / LINE_BYTES;
  localparam int LIDX_W = $clog2(LINES);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

  logic [LINE_W-1:0] mem [LINES];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              sel_d_q, we_q;
  logic [LINE_W-1:0] snap_q;
  logic [LINE_W-1:0] i_data_q, d_data_q;

  logic              accept, grant_d, grant_i;
  logic [LIDX_W-1:0] i_idx, d_idx, line_idx;
  logic [LINE_W-1:0] rd_line, ld_line;
  logic              load_out, ld_sel_d, ld_we;
  logic              unused_addr_bits;

  // Only the in-range line index matters: byte offset is ignored, high bits wrap.
  assign i_idx    = i_addr_i[OFF_W +: LIDX_W];
  assign d_idx    = d_addr_i[OFF_W +: LIDX_W];
  assign unused_addr_bits = ^{i_addr_i[ADDR_W-1:OFF_W+LIDX_W], i_addr_i[OFF_W-1:0],
                              d_addr_i[ADDR_W-1:OFF_W+LIDX_W], d_addr_i[OFF_W-1:0]};

  assign accept   = rst_n && (state_q == IDLE) && (i_req_i || d_req_i);
  assign line_idx = grant_d ? d_idx : i_idx;
  assign rd_line  = mem[line_idx];

  line_mem_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_d   (d_req_i),
    .req_i   (i_req_i),
    .advance (accept),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (RD_LAT == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == LAST_CNT) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With a one-cycle latency the response data comes straight from the array.
  always_comb begin
    load_out = (state_d == RESP) && (state_q != RESP);
    ld_line  = snap_q;
    ld_sel_d = sel_d_q;
    ld_we    = we_q;
    if (state_q == IDLE) begin
      ld_line  = rd_line;
      ld_sel_d = grant_d;
      ld_we    = d_we_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_d_q <= 1'b0;
      we_q    <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= CNT_W'(1);
        sel_d_q <= grant_d;
        we_q    <= grant_d && d_we_i;
        snap_q  <= rd_line;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_data_q <= '0;
      d_data_q <= '0;
    end else if (load_out) begin
      if (ld_sel_d) begin
        if (!ld_we) d_data_q <= ld_line;
      end else begin
        i_data_q <= ld_line;
      end
    end
  end

  // Storage is never reset so contents survive an aborted transaction.
  always_ff @(posedge clk) begin
    if (accept && grant_d && d_we_i) begin
      for (int k = 0; k < LINE_BYTES; k++) begin
        if (d_be_i[k]) mem[d_idx][8*k +: 8] <= d_wdata_i[8*k +: 8];
      end
    end
  end

  assign i_data_o  = i_data_q;
  assign d_data_o  = d_data_q;
  assign i_ready_o = (state_q == RESP) && !sel_d_q;
  assign d_ready_o = (state_q == RESP) && sel_d_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_line_mem.sv
// Self-checking bench for line_mem against a byte-array reference model.
module tb_line_mem;

  localparam int LB     = 16;
  localparam int MB     = 4096;
  localparam int RD_LAT = 3;
  localparam int AW     = 32;

  logic            clk;
  logic            rst_n;
  logic            i_req_i;
  logic [AW-1:0]   i_addr_i;
  logic [8*LB-1:0] i_data_o;
  logic            i_ready_o;
  logic            d_req_i;
  logic            d_we_i;
  logic [AW-1:0]   d_addr_i;
  logic [LB-1:0]   d_be_i;
  logic [8*LB-1:0] d_wdata_i;
  logic [8*LB-1:0] d_data_o;
  logic            d_ready_o;
  logic            busy_o;

  int compared;
  int mismatched;

  logic [7:0]      ref_mem [MB];
  bit              prio_d;
  logic [8*LB-1:0] exp_d;
  logic [8*LB-1:0] exp_i;
  logic [31:0]     pool [8];

  line_mem #(
    .LINE_BYTES (LB),
    .MEM_BYTES  (MB),
    .RD_LAT     (RD_LAT),
    .ADDR_W     (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_i   (i_req_i),
    .i_addr_i  (i_addr_i),
    .i_data_o  (i_data_o),
    .i_ready_o (i_ready_o),
    .d_req_i   (d_req_i),
    .d_we_i    (d_we_i),
    .d_addr_i  (d_addr_i),
    .d_be_i    (d_be_i),
    .d_wdata_i (d_wdata_i),
    .d_data_o  (d_data_o),
    .d_ready_o (d_ready_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lineBase(input logic [31:0] addr);
    return (int'(addr % MB) / LB) * LB;
  endfunction

  function automatic logic [8*LB-1:0] modelRead(input logic [31:0] addr);
    logic [8*LB-1:0] line;
    int base;
    base = lineBase(addr);
    for (int k = 0; k < LB; k++) line[8*k +: 8] = ref_mem[base + k];
    return line;
  endfunction

  task automatic modelWrite(input logic [31:0] addr, input logic [LB-1:0] be,
                            input logic [8*LB-1:0] data);
    int base;
    base = lineBase(addr);
    for (int k = 0; k < LB; k++) if (be[k]) ref_mem[base + k] = data[8*k +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [8*LB-1:0] observed,
                             input logic [8*LB-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit rq_d, input bit rq_i, input bit we,
                               input logic [31:0] daddr, input logic [31:0] iaddr,
                               input logic [LB-1:0] be, input logic [8*LB-1:0] wdata);
    d_req_i   = rq_d;
    i_req_i   = rq_i;
    d_we_i    = we;
    d_addr_i  = daddr;
    i_addr_i  = iaddr;
    d_be_i    = be;
    d_wdata_i = wdata;
  endtask

  // One arbitrated transaction starting from a negedge in IDLE.
  task automatic serve(input bit rq_d, input bit rq_i, input bit we,
                       input logic [31:0] daddr, input logic [31:0] iaddr,
                       input logic [LB-1:0] be, input logic [8*LB-1:0] wdata);
    bit win_d;
    bit seen;
    int lat;
    win_d = rq_d && (!rq_i || prio_d);
    applyStimulus(rq_d, rq_i, we, daddr, iaddr, be, wdata);
    @(posedge clk);
    prio_d = !win_d;
    if (win_d) begin
      if (we) modelWrite(daddr, be, wdata);
      else exp_d = modelRead(daddr);
    end else begin
      exp_i = modelRead(iaddr);
    end
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= RD_LAT + 3 && !seen; c++) begin
      @(negedge clk);
      if (win_d ? d_ready_o : i_ready_o) begin
        seen = 1'b1;
        lat  = c;
      end
      checkOutput("loser_ready", win_d ? i_ready_o : d_ready_o, 0);
      checkOutput("busy_active", busy_o, 1);
    end
    checkOutput("ready_seen", seen, 1);
    checkOutput("latency", lat, RD_LAT);
    checkOutput("d_data", d_data_o, exp_d);
    checkOutput("i_data", i_data_o, exp_i);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pulse_width", win_d ? d_ready_o : i_ready_o, 0);
    checkOutput("idle_busy", busy_o, 0);
  endtask

  initial begin
    logic [8*LB-1:0] ramp;
    logic [8*LB-1:0] rdata;
    logic [31:0]     da;
    logic [31:0]     ia;
    int              sel;

    compared   = 0;
    mismatched = 0;
    prio_d     = 1'b1;
    exp_d      = '0;
    exp_i      = '0;
    for (int a = 0; a < MB; a++) ref_mem[a] = 8'h00;
    pool[0] = 32'h000; pool[1] = 32'h100; pool[2] = 32'h200; pool[3] = 32'h330;
    pool[4] = 32'h550; pool[5] = 32'h7F0; pool[6] = 32'hA40; pool[7] = 32'hFF0;

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rst_i_ready", i_ready_o, 0);
    checkOutput("rst_d_ready", d_ready_o, 0);
    checkOutput("rst_i_data", i_data_o, 0);
    checkOutput("rst_d_data", d_data_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < LB; k++) ramp[8*k +: 8] = 8'(k);
    serve(1, 0, 1, 32'h100, 0, 16'hFFFF, ramp);
    serve(1, 0, 0, 32'h100, 0, 0, 0);
    checkOutput("ramp_read", d_data_o, 128'h0F0E0D0C0B0A09080706050403020100);

    serve(1, 0, 1, 32'h200, 0, 16'hFFFF, '0);
    serve(1, 0, 1, 32'h200, 0, 16'h0001, '1);
    serve(1, 0, 0, 32'h200, 0, 0, 0);
    checkOutput("byte0_write", d_data_o, 128'h000000000000000000000000000000FF);

    serve(0, 1, 0, 0, 32'h1107, 0, 0);
    checkOutput("wrap_read", i_data_o, 128'h0F0E0D0C0B0A09080706050403020100);

    for (int p = 0; p < 8; p++) begin
      if (p != 1 && p != 2)
        serve(1, 0, 1, pool[p], 0, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
    end

    serve(1, 0, 1, 32'h330, 0, 16'h0000, '1);
    serve(1, 0, 0, 32'h333, 0, 0, 0);

    // Reset during WAIT: the accepted write stays, no ready pulse appears.
    rdata = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1, 0, 1, 32'h550, 0, 16'hFFFF, rdata);
    @(posedge clk);
    modelWrite(32'h550, 16'hFFFF, rdata);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_d_data", d_data_o, 0);
    checkOutput("abort_i_data", i_data_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < RD_LAT + 1; c++) begin
      @(negedge clk);
      checkOutput("abort_d_ready", d_ready_o, 0);
      checkOutput("abort_i_ready", i_ready_o, 0);
    end
    rst_n  = 1'b1;
    prio_d = 1'b1;
    exp_d  = '0;
    exp_i  = '0;
    @(negedge clk);

    serve(1, 1, 0, 32'h550, 32'h100, 0, 0);
    checkOutput("kept_write", d_data_o, rdata);
    serve(1, 1, 0, 32'h550, 32'h100, 0, 0);
    checkOutput("rr_second_i", i_data_o, 128'h0F0E0D0C0B0A09080706050403020100);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(1, 3);
      da  = ($urandom & 32'hFFFF_F000) | pool[$urandom_range(0, 7)] | ($urandom & 32'hF);
      ia  = ($urandom & 32'hFFFF_F000) | pool[$urandom_range(0, 7)] | ($urandom & 32'hF);
      serve(sel[0], sel[1], 1'($urandom_range(0, 1)), da, ia,
            ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
